// File: rtl/debug_dump_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : debug_dump_receiver
//  Description : Host-side receiver for the debug dump stream. It collects
//                UART bytes (MSB first) into words and tags each word with a
//                section (PC / REG / MEM) and an index. It holds the last PC,
//                pulses on frame completion and pulses on an inter-byte
//                timeout.
//  Ports       : i_clk, i_reset (sync, active-high)
//                i_rx_data/i_rx_valid  byte stream from the receptor
//                i_enable              arm receiver, low aborts the frame
//                o_word/o_word_valid/o_section/o_index  tagged word output
//                o_pc                  last PC word, held
//                o_busy/o_frame_done/o_error  frame status
//                i_rd_addr/i_rd_sel/o_rd_data  capture read port
//  Options     : DEBUG_DUMP_RX_CAPTURE_EN adds the REG/MEM capture arrays.
//                Without it, o_rd_data is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_dump_receiver #(
  parameter int NB_DATA        = 32,
  parameter int NB_BYTE        = 8,
  parameter int N_REGISTERS    = 32,
  parameter int N_ADDR_D_MEM   = 32,
  parameter int NB_INDEX       = 5,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int NB_TIMEOUT     = 17
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_enable,
  output logic [NB_DATA-1:0]  o_word,
  output logic                o_word_valid,
  output logic [1:0]          o_section,
  output logic [NB_INDEX-1:0] o_index,
  output logic [NB_DATA-1:0]  o_pc,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_error,
  input  logic [NB_INDEX-1:0] i_rd_addr,
  input  logic                i_rd_sel,
  output logic [NB_DATA-1:0]  o_rd_data
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [1:0] SEC_PC  = 2'b00;
  localparam logic [1:0] SEC_REG = 2'b01;
  localparam logic [1:0] SEC_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PC   = 2'd1,
    ST_REG  = 2'd2,
    ST_MEM  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_INDEX-1:0] index_q, index_d;
  logic [NB_DATA-1:0]  shift_q, shift_d;
  logic [NB_TIMEOUT-1:0] timer_q, timer_d;
  logic                busy_q, busy_d;
  logic [NB_DATA-1:0]  word_q, word_d;
  logic                word_valid_q, word_valid_d;
  logic [1:0]          section_q, section_d;
  logic [NB_INDEX-1:0] out_index_q, out_index_d;
  logic [NB_DATA-1:0]  pc_q, pc_d;
  logic                frame_done_q, frame_done_d;
  logic                error_q, error_d;

  logic [NB_DATA-1:0]  new_word;
  logic                last_byte;
  logic                timeout_hit;

  assign new_word    = {shift_q[NB_DATA-NB_BYTE-1:0], i_rx_data};
  assign last_byte   = (cnt_q == NB_CNT'(N_BYTES - 1));
  // A byte in the firing cycle takes priority, so the abort needs !i_rx_valid.
  assign timeout_hit = busy_q && !i_rx_valid &&
                       (timer_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    index_d      = index_q;
    shift_d      = shift_q;
    timer_d      = timer_q;
    busy_d       = busy_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    section_d    = section_q;
    out_index_d  = out_index_q;
    pc_d         = pc_q;
    frame_done_d = 1'b0;
    error_d      = 1'b0;

    // Silence timer: runs only inside a frame and saturates at the trip value.
    if (busy_q && (timer_q != NB_TIMEOUT'(TIMEOUT_CYCLES - 1))) begin
      timer_d = timer_q + NB_TIMEOUT'(1);
    end

    if (state_q == ST_IDLE) begin
      if (i_enable) begin
        state_d = ST_PC;
      end
      cnt_d   = '0;
      index_d = '0;
      timer_d = '0;
      busy_d  = 1'b0;
    end else if (!i_enable) begin
      // Quiet abort: partial data dropped, o_pc untouched, no status pulse.
      state_d = ST_IDLE;
      cnt_d   = '0;
      index_d = '0;
      shift_d = '0;
      timer_d = '0;
      busy_d  = 1'b0;
    end else if (i_rx_valid) begin
      shift_d = new_word;
      timer_d = '0;
      busy_d  = 1'b1;
      cnt_d   = last_byte ? '0 : cnt_q + NB_CNT'(1);
      if (last_byte) begin
        word_d       = new_word;
        word_valid_d = 1'b1;
        out_index_d  = index_q;
        if (state_q == ST_PC) begin
          section_d = SEC_PC;
          pc_d      = new_word;
          state_d   = ST_REG;
          index_d   = '0;
        end else if (state_q == ST_REG) begin
          section_d = SEC_REG;
          if (index_q == NB_INDEX'(N_REGISTERS - 1)) begin
            state_d = ST_MEM;
            index_d = '0;
          end else begin
            index_d = index_q + NB_INDEX'(1);
          end
        end else begin
          section_d = SEC_MEM;
          if (index_q == NB_INDEX'(N_ADDR_D_MEM - 1)) begin
            // i_enable is known high here, so the next frame starts at PC.
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_PC;
            index_d      = '0;
          end else begin
            index_d = index_q + NB_INDEX'(1);
          end
        end
      end
    end else if (timeout_hit) begin
      error_d = 1'b1;
      state_d = ST_PC;
      cnt_d   = '0;
      index_d = '0;
      shift_d = '0;
      timer_d = '0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      index_q      <= '0;
      shift_q      <= '0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      section_q    <= '0;
      out_index_q  <= '0;
      pc_q         <= '0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      index_q      <= index_d;
      shift_q      <= shift_d;
      timer_q      <= timer_d;
      busy_q       <= busy_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      section_q    <= section_d;
      out_index_q  <= out_index_d;
      pc_q         <= pc_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = word_valid_q;
  assign o_section    = section_q;
  assign o_index      = out_index_q;
  assign o_pc         = pc_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_error      = error_q;

`ifdef DEBUG_DUMP_RX_CAPTURE_EN
  logic [NB_DATA-1:0] cap_reg_q [2**NB_INDEX];
  logic [NB_DATA-1:0] cap_mem_q [2**NB_INDEX];
  logic [NB_DATA-1:0] rd_data_q, rd_data_d;

  // Written from the registered word outputs; no reset on the storage.
  always_ff @(posedge i_clk) begin
    if (word_valid_q && (section_q == SEC_REG)) begin
      cap_reg_q[out_index_q] <= word_q;
    end
    if (word_valid_q && (section_q == SEC_MEM)) begin
      cap_mem_q[out_index_q] <= word_q;
    end
  end

  // Read samples the arrays before this edge's write, giving old data on a collision.
  always_comb begin
    rd_data_d = i_rd_sel ? cap_mem_q[i_rd_addr] : cap_reg_q[i_rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;
`else
  logic unused_rd;
  assign unused_rd = ^{i_rd_addr, i_rd_sel};
  assign o_rd_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_debug_dump_receiver
//  Description : Self-checking bench for debug_dump_receiver. A word-level
//                model derives section/index/frame_done from the position of
//                each word in the frame and keeps the expected PC and the
//                expected REG/MEM capture contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_dump_receiver;

  localparam int NB_DATA     = 32;
  localparam int NB_BYTE     = 8;
  localparam int N_REG       = 32;
  localparam int N_MEM       = 32;
  localparam int NB_INDEX    = 5;
  localparam int TO          = 40;
  localparam int NB_TO       = 6;
  localparam int FRAME_WORDS = 1 + N_REG + N_MEM;

  logic                i_clk;
  logic                i_reset;
  logic [NB_BYTE-1:0]  i_rx_data;
  logic                i_rx_valid;
  logic                i_enable;
  logic [NB_DATA-1:0]  o_word;
  logic                o_word_valid;
  logic [1:0]          o_section;
  logic [NB_INDEX-1:0] o_index;
  logic [NB_DATA-1:0]  o_pc;
  logic                o_busy;
  logic                o_frame_done;
  logic                o_error;
  logic [NB_INDEX-1:0] i_rd_addr;
  logic                i_rd_sel;
  logic [NB_DATA-1:0]  o_rd_data;

  debug_dump_receiver #(
    .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .N_REGISTERS(N_REG),
    .N_ADDR_D_MEM(N_MEM), .NB_INDEX(NB_INDEX),
    .TIMEOUT_CYCLES(TO), .NB_TIMEOUT(NB_TO)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .i_enable(i_enable), .o_word(o_word),
    .o_word_valid(o_word_valid), .o_section(o_section), .o_index(o_index),
    .o_pc(o_pc), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_error(o_error), .i_rd_addr(i_rd_addr), .i_rd_sel(i_rd_sel),
    .o_rd_data(o_rd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  sec;
    logic [4:0]  idx;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          err_cnt = 0;
  int          done_cnt = 0;
  int          frame_pos = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word monitor: every output word is matched against the model queue.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_reset && o_error) err_cnt++;
    if (!i_reset && o_frame_done) done_cnt++;
    if (!i_reset && o_word_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $error("FAIL unexpected_word observed=%0h expected=none", o_word);
      end else begin
        e = exp_q.pop_front();
        if (e.sec == 2'b00) exp_pc = e.word;
        else if (e.sec == 2'b01) m_reg[e.idx] = e.word;
        else m_mem[e.idx] = e.word;
        check("word", o_word, e.word);
        check("section", o_section, e.sec);
        check("index", o_index, e.idx);
        check("frame_done", o_frame_done, e.done);
        check("busy_with_word", o_busy, !e.done);
        check("pc", o_pc, exp_pc);
      end
    end else if (!i_reset && o_frame_done) begin
      n_vec++;
      n_bad++;
      $error("FAIL stray_frame_done observed=1 expected=0");
    end
  end

  // Position in the frame decides the tag: 0 is PC, then REGs, then MEMs.
  task automatic push_word(input logic [31:0] w);
    exp_t e;
    e.word = w;
    e.done = (frame_pos == FRAME_WORDS - 1);
    if (frame_pos == 0) begin
      e.sec = 2'b00; e.idx = 5'd0;
    end else if (frame_pos <= N_REG) begin
      e.sec = 2'b01; e.idx = 5'(frame_pos - 1);
    end else begin
      e.sec = 2'b10; e.idx = 5'(frame_pos - 1 - N_REG);
    end
    frame_pos = e.done ? 0 : frame_pos + 1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd_gap);
    push_word(w);
    for (int i = 0; i < 4; i++) begin
      if (rnd_gap && i > 0) idle($urandom_range(0, 2));
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic send_rand_frame();
    for (int k = 0; k < FRAME_WORDS; k++) begin
      idle($urandom_range(0, 2));
      send_word($urandom, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          e0;
    int          d0;
    logic [31:0] exp_rd;
    logic [4:0]  r;

    i_reset = 1'b1; i_enable = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0;
    i_rd_addr = '0; i_rd_sel = 1'b0;
    idle(3);
    check("rst_word", o_word, 0);
    check("rst_valid", o_word_valid, 0);
    check("rst_section", o_section, 0);
    check("rst_index", o_index, 0);
    check("rst_pc", o_pc, 0);
    check("rst_busy", o_busy, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_error", o_error, 0);
    check("rst_rd_data", o_rd_data, 0);
    i_reset = 1'b0;

    // PC word, valid one cycle after the 4th byte.
    i_enable = 1'b1;
    idle(2);
    push_word(32'h0000_002C);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h2C);
    check("t1_valid", o_word_valid, 1);
    check("t1_word", o_word, 32'h2C);
    check("t1_pc", o_pc, 32'h2C);
    check("t1_busy", o_busy, 1);
    idle(1);
    check("t1_valid_pulse", o_word_valid, 0);

    // Rest of the frame: REG k = k, MEM k = 0x100+k.
    for (int k = 0; k < N_REG; k++) begin
      idle($urandom_range(0, 2));
      send_word(32'(k), 1'b1);
    end
    for (int k = 0; k < N_MEM; k++) begin
      idle($urandom_range(0, 2));
      send_word(32'h100 + 32'(k), 1'b1);
    end
    check("t2_frame_done", o_frame_done, 1);
    check("t2_last_word", o_word, 32'h11F);
    check("t2_busy_drop", o_busy, 0);
    idle(1);
    check("t2_done_pulse", o_frame_done, 0);
    idle(2);
    check("t2_drained", exp_q.size(), 0);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_no_error", err_cnt, 0);

    // Capture read port.
    i_rd_sel = 1'b1; i_rd_addr = 5'd5;
    idle(1);
`ifdef DEBUG_DUMP_RX_CAPTURE_EN
    exp_rd = 32'h105;
`else
    exp_rd = 32'h0;
`endif
    check("rd_mem5", o_rd_data, exp_rd);
    for (int j = 0; j < 3; j++) begin
      r = 5'($urandom_range(0, 31));
      i_rd_sel = j[0]; i_rd_addr = r;
      idle(1);
`ifdef DEBUG_DUMP_RX_CAPTURE_EN
      exp_rd = j[0] ? m_mem[r] : m_reg[r];
`else
      exp_rd = 32'h0;
`endif
      check("rd_rand", o_rd_data, exp_rd);
    end

    // Timeout: 2 bytes then TO silent cycles; following bytes form a PC word.
    e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'hBB);
    check("t3_busy", o_busy, 1);
    idle(TO);
    frame_pos = 0;
    send_word($urandom, 1'b0);
    idle(2);
    check("t3_error", err_cnt, e0 + 1);
    check("t3_drained", exp_q.size(), 0);
    check("t3_pc", o_pc, exp_pc);

    // Byte lands exactly on the timeout cycle: no error, word completes.
    e0 = err_cnt;
    push_word(32'hCAFE_0001);
    send_byte(8'hCA); send_byte(8'hFE);
    idle(TO - 1);
    send_byte(8'h00); send_byte(8'h01);
    idle(2);
    check("t5_no_error", err_cnt, e0);
    check("t5_drained", exp_q.size(), 0);

    // Enable drop after 10 REG words plus a partial word.
    for (int k = 0; k < 9; k++) send_word($urandom, 1'b1);
    send_byte(8'h55);
    d0 = done_cnt; e0 = err_cnt;
    i_enable = 1'b0;
    idle(2);
    check("t4_busy", o_busy, 0);
    check("t4_pc_kept", o_pc, exp_pc);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom));
    idle(TO + 2);
    check("t4_no_error", err_cnt, e0);
    check("t4_no_done", done_cnt, d0);
    check("t4_ignored", exp_q.size(), 0);
    i_enable = 1'b1;
    frame_pos = 0;
    idle(1);
    send_rand_frame();
    idle(2);
    check("t4_refram_done", done_cnt, d0 + 1);
    check("t4_drained", exp_q.size(), 0);
    check("t4_pc", o_pc, exp_pc);

    // Reset mid-frame acts as power-on reset.
    send_word($urandom, 1'b0);
    send_byte(8'h12); send_byte(8'h34);
    i_reset = 1'b1;
    idle(2);
    exp_q.delete();
    frame_pos = 0;
    exp_pc = '0;
    check("rst2_pc", o_pc, 0);
    check("rst2_busy", o_busy, 0);
    check("rst2_valid", o_word_valid, 0);
    i_reset = 1'b0;
    idle(2);
    send_word($urandom, 1'b1);
    idle(2);
    check("rst2_pc_word", exp_q.size(), 0);
    check("rst2_pc_val", o_pc, exp_pc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
